// File: rtl/relu_wb_sched_if.sv
// Bundle between the conv lanes, the shared ReLU unit, the output memory and relu_wb_sched.
// The slave modport is the scheduler's view of the bundle.
interface relu_wb_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 23,
  parameter int ADDR_W = 16
);
  logic                    start;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        gnt;
  logic                    relu_en;
  logic [DATA_W-1:0]       relu_in;
  logic [DATA_W-1:0]       relu_out;
  logic                    relu_write;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport slave (
    input  start, req, data, relu_out, relu_write,
    output gnt, relu_en, relu_in, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport master (
    output start, req, data, relu_out, relu_write,
    input  gnt, relu_en, relu_in, mem_we, mem_addr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/relu_wb_sched.sv
// Round-robin sharing of one 2-cycle ReLU among N_REQ conv lanes, with a tag pipeline
// that turns ReLU results into raster-addressed output-memory writes.
module relu_wb_lane #(
  parameter int FRAME = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] pix,
  output logic             fin,
  output logic             last
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pix <= '0;
    else if (clr) pix <= '0;
    else if (inc) pix <= pix + CNT_W'(1);
  end

  assign fin  = (pix == CNT_W'(FRAME));
  assign last = (pix == CNT_W'(FRAME - 1));
endmodule

module relu_wb_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 23,
  parameter int FMAP_W = 55,
  parameter int FMAP_H = 55,
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  relu_wb_sched_if.slave bus
);
  localparam int FRAME  = FMAP_W * FMAP_H;
  localparam int CNT_W  = $clog2(FRAME + 1);
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state, nstate;
  logic [PTR_W-1:0]            ptr, gidx, cand;
  logic                        found, clr;
  logic [N_REQ-1:0]            gnt_c, lane_done, lane_last, eligible;
  logic [N_REQ-1:0][CNT_W-1:0] pix;
  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][ADDR_W-1:0] addr_pipe;
  logic [ADDR_W-1:0]           gaddr, mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_we, err, wr_hit;

  assign clr = (state == IDLE) && bus.start;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_lane
      relu_wb_lane #(.FRAME(FRAME), .CNT_W(CNT_W)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (gnt_c[g]),
        .pix  (pix[g]),
        .fin  (lane_done[g]),
        .last (lane_last[g])
      );
    end
  endgenerate

  assign eligible = bus.req & ~lane_done;

  // First eligible lane scanning upward from ptr, wrapping at N_REQ.
  always_comb begin
    gnt_c = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    if (state == RUN) begin
      for (int off = 0; off < N_REQ; off++) begin
        cand = PTR_W'((int'(ptr) + off) % N_REQ);
        if (!found && eligible[cand]) begin
          found       = 1'b1;
          gidx        = cand;
          gnt_c[cand] = 1'b1;
        end
      end
    end
  end

  assign gaddr = ADDR_W'(int'(gidx) * FRAME) + ADDR_W'(pix[gidx]);

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (bus.start) nstate = RUN;
      RUN:     if (&(lane_done | (gnt_c & lane_last))) nstate = DRAIN;
      DRAIN:   if (vld_pipe == '0) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // With stage2 invalid, relu_write is ignored, so an unreset ReLU cannot leak a write.
  assign wr_hit = vld_pipe[STAGES] & bus.relu_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      vld_pipe  <= '0;
      addr_pipe <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      state <= nstate;
      if (clr)
        ptr <= '0;
      else if (found)
        ptr <= (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);

      vld_pipe[1] <= found;
      if (found) addr_pipe[1] <= gaddr;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        addr_pipe[s] <= addr_pipe[s-1];
      end

      mem_we <= wr_hit;
      if (wr_hit) begin
        mem_addr  <= addr_pipe[STAGES];
        mem_wdata <= bus.relu_out;
      end

      if (clr)
        err <= 1'b0;
      else if (vld_pipe[STAGES] && !bus.relu_write)
        err <= 1'b1;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.relu_en   = found;
  assign bus.relu_in   = found ? bus.data[int'(gidx)*DATA_W +: DATA_W] : '0;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.err       = err;
endmodule

// File: tb/tb_relu_wb_sched.sv
// Directed bench for relu_wb_sched on a 2x2 feature map, with a 2-cycle ReLU model
// and a write scoreboard that also pins the grant-to-write latency.
module tb_relu_wb_sched;
  localparam int N  = 4;
  localparam int DW = 23;
  localparam int AW = 16;
  localparam int FW = 2;
  localparam int FH = 2;
  localparam int FR = FW * FH;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t mon_e;
  int   pix_m[N];
  logic [DW-1:0] dat[N];

  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [DW-1:0] p1_d = '0, p2_d = '0;
  logic          kill = 1'b0;
  logic          relu_x = 1'b0;

  relu_wb_sched_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  relu_wb_sched #(.N_REQ(N), .DATA_W(DW), .FMAP_W(FW), .FMAP_H(FH), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ReLU model: unreset, fixed 2-cycle latency; kill suppresses the write for one cycle.
  always @(posedge clk) begin
    p1_v <= bus.relu_en;
    p1_d <= bus.relu_in;
    p2_v <= p1_v;
    p2_d <= p1_d;
  end
  assign bus.relu_out   = p2_d[DW-1] ? '0 : p2_d;
  assign bus.relu_write = relu_x ? 1'bx : (p2_v & ~kill);

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
    return d[DW-1] ? '0 : d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.mem_we === 1'b1) begin
      if (q.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(bus.mem_wdata), 32'(mon_e.wdata));
        chk("wr_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int l = 0; l < N; l++) bus.data[l*DW +: DW] = dat[l];
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    bus.req   = '0;
    step();
    bus.start = 1'b0;
    for (int l = 0; l < N; l++) pix_m[l] = 0;
  endtask

  // One cycle where exactly lane `lane` must be granted.
  task automatic grant_cycle(input logic [N-1:0] r, input int lane, input bit drop, input bit rnd);
    bus.req = r;
    if (rnd) for (int l = 0; l < N; l++) dat[l] = DW'($urandom);
    drive_data();
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), 32'(4'b0001 << lane));
    chk("relu_in", 32'(bus.relu_in), 32'(dat[lane]));
    chk("busy_run", 32'(bus.busy), 32'd1);
    if (!drop)
      q.push_back('{addr: AW'(lane * FR + pix_m[lane]), wdata: relu(dat[lane]), cyc: cyc + 3});
    pix_m[lane]++;
    step();
  endtask

  task automatic idle_chk(input logic [N-1:0] r, input int n);
    bus.req = r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("gnt_none", 32'(bus.gnt), 32'd0);
      chk("relu_en_none", 32'(bus.relu_en), 32'd0);
      step();
    end
  endtask

  // Call right after the final grant: done must pulse exactly 4 cycles later.
  task automatic done_seq();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("drain_gnt", 32'(bus.gnt), 32'd0);
      chk("done_lat", 32'(bus.done), (i == 4) ? 32'd1 : 32'd0);
      chk("busy_drain", 32'(bus.busy), (i == 4) ? 32'd0 : 32'd1);
      step();
    end
    bus.req = '0;
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.req   = '0;
    bus.data  = '0;
    for (int l = 0; l < N; l++) dat[l] = '0;

    // Test 1: async reset mid-cycle with X on relu_write.
    relu_x = 1'b1;
    #3 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_relu_en", 32'(bus.relu_en), 32'd0);
    chk("rst_relu_in", 32'(bus.relu_in), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_we", 32'(bus.mem_we), 32'd0);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      step();
    end
    relu_x = 1'b0;
    idle_chk('0, 2);

    // Test 2: single lane, negative then positive sample.
    do_start();
    dat[0] = 23'h400005;
    grant_cycle(4'b0001, 0, 1'b0, 1'b0);
    dat[0] = 23'h000123;
    grant_cycle(4'b0001, 0, 1'b0, 1'b0);
    idle_chk('0, 5);

    // Test 5: reset with two samples in flight, relu_write still pulses afterwards.
    grant_cycle(4'b0010, 1, 1'b1, 1'b1);
    grant_cycle(4'b0010, 1, 1'b1, 1'b1);
    bus.req = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst5_busy", 32'(bus.busy), 32'd0);
    chk("rst5_err", 32'(bus.err), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst5_we", 32'(bus.mem_we), 32'd0);
      chk("rst5_err_after", 32'(bus.err), 32'd0);
      step();
    end

    // Test 3: all lanes requesting, strict round robin, raster addresses from 0.
    do_start();
    dat[0] = 23'h000011; dat[1] = 23'h7FFFFF; dat[2] = 23'h3FFFFF; dat[3] = 23'h400000;
    for (int k = 0; k < N * FR; k++) grant_cycle(4'b1111, k % N, 1'b0, 1'b0);
    done_seq();
    idle_chk('0, 2);

    // Test 4: lanes 1 and 3 alternate; finished lanes are skipped while req stays high.
    do_start();
    for (int k = 0; k < 2 * FR; k++) grant_cycle(4'b1010, (k % 2 == 0) ? 1 : 3, 1'b0, 1'b1);
    idle_chk(4'b1010, 2);
    for (int k = 0; k < 2 * FR; k++) grant_cycle(4'b0101, (k % 2 == 0) ? 0 : 2, 1'b0, 1'b1);
    done_seq();
    idle_chk('0, 2);

    // Test 6: start ignored in RUN; one suppressed ReLU write raises sticky err.
    do_start();
    grant_cycle(4'b0001, 0, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.req   = '0;
    @(negedge clk);
    chk("start_in_run_busy", 32'(bus.busy), 32'd1);
    step();
    bus.start = 1'b0;
    grant_cycle(4'b0001, 0, 1'b0, 1'b1);
    grant_cycle(4'b0100, 2, 1'b1, 1'b1);
    bus.req = '0;
    step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(bus.err), 32'd1);
    chk("err_no_we", 32'(bus.mem_we), 32'd0);
    step();
    for (int l = 0; l < N; l++)
      while (pix_m[l] < FR) grant_cycle(4'(4'b0001 << l), l, 1'b0, 1'b1);
    done_seq();
    @(negedge clk);
    chk("err_sticky", 32'(bus.err), 32'd1);
    step();
    do_start();
    @(negedge clk);
    chk("err_cleared", 32'(bus.err), 32'd0);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    step();
    idle_chk('0, 4);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
